// File: rtl/cic_ctrl.sv
// cic_ctrl: sequencing and configuration controller for a CIC decimator.
// It accepts range-checked ratio changes and flushes the CIC through its reset.
// It discards the start-up transient, then forwards qualified decimated samples.
// A watchdog trips to FAULT when the CIC output strobe stops toggling.
module cic_ctrl #(
  parameter int RATIO_W        = 16,
  parameter int DATA_W         = 8,
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_OUTPUTS = 3,
  parameter int MIN_RATIO      = 2,
  parameter int MAX_RATIO      = 1024,
  parameter int RESET_RATIO    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [RATIO_W-1:0] cfg_ratio,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               cic_rst,
  output logic [RATIO_W-1:0] cic_ratio,
  input  logic               cic_d_clk,
  input  logic [DATA_W-1:0]  cic_d_out,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy,
  output logic               fault
);

  localparam int WD_W  = RATIO_W + 3;
  localparam int CNT_W = $clog2(FLUSH_CYCLES + SETTLE_OUTPUTS + 1) + 1;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [WD_W-1:0]    wd_cnt_r;
  logic [WD_W-1:0]    wd_cnt_nxt_s;
  logic [WD_W-1:0]    wd_limit_s;
  logic               wd_expired_s;
  logic               d_clk_q_r;
  logic               edge_s;
  logic               hs_s;
  logic               legal_s;
  logic               legal_hs_s;
  logic               flush_done_s;
  logic               settle_done_s;
  logic               emit_s;
  logic               cic_rst_r;
  logic [RATIO_W-1:0] cic_ratio_r;
  logic               cfg_err_r;
  logic               out_valid_r;
  logic [DATA_W-1:0]  out_data_r;

  // Decoded handshake, strobe edge, counter terminal counts and watchdog limit.
  assign edge_s        = cic_d_clk & ~d_clk_q_r;
  assign hs_s          = cfg_valid & cfg_ready;
  assign legal_s       = (cfg_ratio >= RATIO_W'(MIN_RATIO)) && (cfg_ratio <= RATIO_W'(MAX_RATIO));
  assign legal_hs_s    = hs_s & legal_s;
  assign flush_done_s  = (cnt_r == CNT_W'(FLUSH_CYCLES - 1));
  assign settle_done_s = (cnt_r == CNT_W'(SETTLE_OUTPUTS - 1));
  // Expiry is flagged one count early so FAULT is entered as the counter would reach the limit.
  assign wd_limit_s    = ({3'b000, cic_ratio_r} << 2) + WD_W'(16);
  assign wd_expired_s  = (wd_cnt_r == (wd_limit_s - WD_W'(1)));
  assign emit_s        = (state_r == ST_RUN) & edge_s & ~legal_hs_s;

  // State decodes that are allowed to be combinational.
  assign cfg_ready = (state_r == ST_RUN) || (state_r == ST_FAULT);
  assign busy      = (state_r == ST_FLUSH) || (state_r == ST_SETTLE);
  assign fault     = (state_r == ST_FAULT);
  assign cic_rst   = cic_rst_r;
  assign cic_ratio = cic_ratio_r;
  assign cfg_err   = cfg_err_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Next-state selection; a legal handshake outranks both edges and watchdog expiry.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FLUSH: begin
        if (flush_done_s) state_nxt_s = ST_SETTLE;
        else              state_nxt_s = ST_FLUSH;
      end
      ST_SETTLE: begin
        if (edge_s) begin
          if (settle_done_s) state_nxt_s = ST_RUN;
          else               state_nxt_s = ST_SETTLE;
        end else if (wd_expired_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_RUN: begin
        if (legal_hs_s)                    state_nxt_s = ST_FLUSH;
        else if (!edge_s && wd_expired_s)  state_nxt_s = ST_FAULT;
        else                               state_nxt_s = ST_RUN;
      end
      ST_FAULT: begin
        if (legal_hs_s) state_nxt_s = ST_FLUSH;
        else            state_nxt_s = ST_FAULT;
      end
      default: state_nxt_s = ST_FLUSH;
    endcase
  end

  // Phase counter: flush cycles in FLUSH, accepted edges in SETTLE, cleared on state entry.
  always_comb begin
    cnt_nxt_s = {CNT_W{1'b0}};
    if (state_nxt_s != state_r)                 cnt_nxt_s = {CNT_W{1'b0}};
    else if (state_r == ST_FLUSH)               cnt_nxt_s = cnt_r + CNT_W'(1);
    else if ((state_r == ST_SETTLE) && edge_s)  cnt_nxt_s = cnt_r + CNT_W'(1);
    else if (state_r == ST_SETTLE)              cnt_nxt_s = cnt_r;
    else                                        cnt_nxt_s = {CNT_W{1'b0}};
  end

  // Watchdog: counts edgeless cycles in SETTLE/RUN, cleared on each edge and state entry.
  always_comb begin
    wd_cnt_nxt_s = {WD_W{1'b0}};
    if (edge_s || (state_nxt_s != state_r))                   wd_cnt_nxt_s = {WD_W{1'b0}};
    else if ((state_r == ST_SETTLE) || (state_r == ST_RUN))   wd_cnt_nxt_s = wd_cnt_r + WD_W'(1);
    else                                                      wd_cnt_nxt_s = {WD_W{1'b0}};
  end

  // State, counters and strobe-edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_FLUSH;
      cnt_r     <= {CNT_W{1'b0}};
      wd_cnt_r  <= {WD_W{1'b0}};
      d_clk_q_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      wd_cnt_r  <= wd_cnt_nxt_s;
      d_clk_q_r <= cic_d_clk;
    end
  end

  // Registered CIC controls and host/sample outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cic_rst_r   <= 1'b1;
      cic_ratio_r <= RATIO_W'(RESET_RATIO);
      cfg_err_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else begin
      cic_rst_r   <= (state_nxt_s == ST_FLUSH) || (state_nxt_s == ST_FAULT);
      if (legal_hs_s) cic_ratio_r <= cfg_ratio;
      cfg_err_r   <= hs_s & ~legal_s;
      out_valid_r <= emit_s;
      if (emit_s) out_data_r <= cic_d_out;
    end
  end

endmodule

// File: tb/tb_cic_ctrl.sv
// tb_cic_ctrl: randomized self-checking bench for cic_ctrl with a behavioural model.
module tb_cic_ctrl;
  localparam int F_CYC = 4;
  localparam int S_OUT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_ratio = 16'd0;
  logic        cfg_ready, cfg_err, cic_rst, out_valid, busy, fault;
  logic [15:0] cic_ratio;
  logic        cic_d_clk = 1'b0;
  logic [7:0]  cic_d_out = 8'd0;
  logic [7:0]  out_data;

  cic_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ratio(cfg_ratio),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .cic_rst(cic_rst), .cic_ratio(cic_ratio),
    .cic_d_clk(cic_d_clk), .cic_d_out(cic_d_out), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // behavioural model: phase is derived from flush age, settled edge count and fault flag
  int       m_ratio, m_age, m_settled, m_quiet;
  bit       m_fault, m_prev, m_err, m_ov;
  logic [7:0] m_od;

  // stimulus bookkeeping
  int  dper = 8, dphase = 4, next_per = 8, stall_left = 0;
  bit  stall = 1'b0;
  bit  b_prev = 1'b0;
  int  b_edge_cnt = 0, b_edge_cyc = 0;
  logic [7:0] b_edge_data = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // 0 = flushing, 1 = settling, 2 = running, 3 = faulted
  function automatic int m_phase();
    if (m_fault)              return 3;
    else if (m_age < F_CYC)   return 0;
    else if (m_settled < S_OUT) return 1;
    else                      return 2;
  endfunction

  task automatic model_reset();
    m_ratio = 4; m_fault = 1'b0; m_age = 0; m_settled = 0; m_quiet = 0;
    m_prev = 1'b0; m_err = 1'b0; m_ov = 1'b0; m_od = 8'd0;
  endtask

  task automatic model_update();
    int ph, limit;
    bit e, hs, lg;
    ph = m_phase();
    e = cic_d_clk && !m_prev;
    m_prev = cic_d_clk;
    hs = cfg_valid && (ph >= 2);
    lg = hs && (cfg_ratio >= 16'd2) && (cfg_ratio <= 16'd1024);
    m_err = hs && !lg;
    m_ov = (ph == 2) && e && !lg;
    if (m_ov) m_od = cic_d_out;
    limit = m_ratio * 4 + 16;
    if (lg) begin
      m_ratio = int'(cfg_ratio); m_fault = 1'b0; m_age = 0; m_settled = 0; m_quiet = 0;
    end else if (ph == 0) begin
      m_age++; m_quiet = 0;
    end else if (ph == 1 || ph == 2) begin
      if (e) begin
        if (ph == 1) m_settled++;
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet >= limit) m_fault = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int ph;
    ph = m_phase();
    check("cfg_ready", 32'(cfg_ready), 32'(ph >= 2));
    check("cic_rst",   32'(cic_rst),   32'(ph == 0 || ph == 3));
    check("cic_ratio", 32'(cic_ratio), 32'(m_ratio));
    check("cfg_err",   32'(cfg_err),   32'(m_err));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("busy",      32'(busy),      32'(ph <= 1));
    check("fault",     32'(fault),     32'(ph == 3));
  endtask

  task automatic drive_dclk();
    if (dphase == 0) dper = next_per;
    cic_d_clk = !stall && (dphase < dper / 2);
    dphase = (dphase + 1) % dper;
    cic_d_out = 8'($urandom);
  endtask

  function automatic bit next_is_edge();
    return rst && cic_d_clk && !b_prev;
  endfunction

  // one clock: model follows the posedge, outputs compared at the negedge
  task automatic step();
    bit e;
    @(posedge clk);
    e = rst && cic_d_clk && !b_prev;
    b_prev = rst ? cic_d_clk : 1'b0;
    if (e) begin b_edge_cnt++; b_edge_cyc = cyc; b_edge_data = cic_d_out; end
    if (rst) model_update(); else model_reset();
    @(negedge clk);
    compare_all();
    cyc++;
    cfg_valid = 1'b0;
    drive_dclk();
  endtask

  task automatic count_flush(input string name);
    int hi;
    hi = int'(cic_rst);
    for (int i = 0; i < 20; i++) begin
      step();
      if (!cic_rst) break;
      hi++;
    end
    check(name, 32'(hi), 32'd4);
  endtask

  initial begin
    bit found;
    model_reset();
    #12;
    check("rst_cic_rst", 32'(cic_rst), 32'd1);
    check("rst_cic_ratio", 32'(cic_ratio), 32'd4);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_fault", 32'(fault), 32'd0);

    // release with the first strobe edge landing on the first settle cycle
    @(negedge clk);
    dper = 8; dphase = 4; next_per = 8;
    drive_dclk();
    #1 rst = 1'b1;
    b_edge_cnt = 0;
    count_flush("flush_len");

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (out_valid) found = 1'b1;
    end
    check("first_valid_seen", 32'(found), 32'd1);
    check("first_valid_edge_no", 32'(b_edge_cnt), 32'd4);
    check("first_valid_latency", 32'(b_edge_cyc), 32'(cyc - 1));
    check("first_valid_data", 32'(out_data), 32'(b_edge_data));

    repeat (10) step();
    // out-of-range requests
    cfg_ratio = 16'd1; cfg_valid = 1'b1; step();
    check("err_lo_pulse", 32'(cfg_err), 32'd1);
    check("err_lo_ratio", 32'(cic_ratio), 32'd4);
    step();
    check("err_lo_clear", 32'(cfg_err), 32'd0);
    cfg_ratio = 16'd1025; cfg_valid = 1'b1; step();
    check("err_hi_pulse", 32'(cfg_err), 32'd1);
    check("err_hi_ratio", 32'(cic_ratio), 32'd4);
    repeat (20) step();

    // stalled strobe at ratio 4 -> FAULT after 32 edgeless cycles
    stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (fault) found = 1'b1;
    end
    check("wd_fault_seen", 32'(found), 32'd1);
    check("wd_fault_delay", 32'(cyc - 1 - b_edge_cyc), 32'd32);
    check("wd_fault_cic_rst", 32'(cic_rst), 32'd1);
    stall = 1'b0;
    cfg_ratio = 16'd8; cfg_valid = 1'b1; step();
    check("recover_fault", 32'(fault), 32'd0);
    check("recover_busy", 32'(busy), 32'd1);
    check("recover_ratio", 32'(cic_ratio), 32'd8);

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin step(); if (!busy) found = 1'b1; end
    check("run_after_recover", 32'(found), 32'd1);
    cfg_ratio = 16'd16; cfg_valid = 1'b1; step();
    check("r16_ready", 32'(cfg_ready), 32'd0);
    check("r16_ratio", 32'(cic_ratio), 32'd16);
    check("r16_cic_rst", 32'(cic_rst), 32'd1);

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin step(); if (!busy) found = 1'b1; end
    check("run_after_r16", 32'(found), 32'd1);
    // legal request on a strobe edge: sample dropped, flush wins
    for (int i = 0; i < 40 && !next_is_edge(); i++) step();
    check("coinc_edge_ready", 32'(next_is_edge()), 32'd1);
    cfg_ratio = 16'd32; cfg_valid = 1'b1; step();
    check("coinc_no_valid", 32'(out_valid), 32'd0);
    check("coinc_busy", 32'(busy), 32'd1);

    // async reset while settling
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin step(); if (busy && !cic_rst) found = 1'b1; end
    check("settle_reached", 32'(found), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_cic_rst", 32'(cic_rst), 32'd1);
    check("async_ratio", 32'(cic_ratio), 32'd4);
    check("async_busy", 32'(busy), 32'd1);
    check("async_ready", 32'(cfg_ready), 32'd0);
    repeat (3) step();
    #1 rst = 1'b1;
    count_flush("reflush_len");

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        cfg_valid = 1'b1;
        case ($urandom_range(0, 6))
          0: cfg_ratio = 16'd0;
          1: cfg_ratio = 16'd1;
          2: cfg_ratio = 16'd2;
          3: cfg_ratio = 16'd1024;
          4: cfg_ratio = 16'd1025;
          5: cfg_ratio = 16'($urandom);
          default: cfg_ratio = 16'($urandom_range(2, 12));
        endcase
      end
      if (stall_left == 0 && $urandom_range(0, 299) == 0) stall_left = $urandom_range(20, 70);
      if (stall_left > 0) stall_left--;
      stall = (stall_left > 0);
      if ($urandom_range(0, 49) == 0) next_per = $urandom_range(4, 12);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
